// File: rtl/serial_excess_coder_if.sv
// Serial excess coder bus.
//   en    : bit-cycle enable
//   start : marks bit 0 of digit 0 of a frame (qualified by en)
//   mode  : 0 = encode (add bias), 1 = decode (subtract bias), sampled on start
//   x     : serial input, LSB first, digit 0 first
//   s     : serial result bit (combinational)
//   v     : per-digit overflow/underflow, valid on the last bit of a digit
//   done  : pulse on the last bit of the last digit
//   err   : registered sticky flag, set by any v of the current or last frame
interface serial_excess_coder_if;
  logic en;
  logic start;
  logic mode;
  logic x;
  logic s;
  logic v;
  logic done;
  logic err;

  modport master (output en, output start, output mode, output x,
                  input s, input v, input done, input err);
  modport slave  (input en, input start, input mode, input x,
                  output s, output v, output done, output err);
endinterface

// File: rtl/serial_excess_coder.sv
// Bit-serial excess-BIAS coder. Each DIGIT_W-bit digit of an NDIGITS-digit frame is
// independently offset by +BIAS (encode) or -BIAS (decode), LSB first. All state
// updates on the falling edge of clk_i.
// Ports:
//   clk_i  : clock (falling edge active)
//   rst_i  : asynchronous active-high reset
//   bus_io : serial_excess_coder_if slave (en/start/mode/x in, s/v/done/err out)
module serial_excess_coder #(
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned NDIGITS = 2,
  parameter int unsigned BIAS    = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  serial_excess_coder_if.slave  bus_io
);

  localparam int unsigned BitW = $clog2(DIGIT_W);
  localparam int unsigned DigW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [DIGIT_W-1:0] BiasVec = DIGIT_W'(BIAS);
  localparam logic [BitW-1:0]    LastBit = BitW'(DIGIT_W - 1);
  localparam logic [DigW-1:0]    LastDig = DigW'(NDIGITS - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [DigW-1:0] dig_q, dig_d;
  logic            c_q, c_d;
  logic            mode_q, mode_d;
  logic            err_q, err_d;

  logic            active;
  logic [BitW-1:0] bit_cur;
  logic [DigW-1:0] dig_cur;
  logic            mode_cur;
  logic            c_cur;
  logic            b;
  logic            c_nxt;
  logic            last_bit;
  logic            s, v, done;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    dig_d   = dig_q;
    c_d     = c_q;
    mode_d  = mode_q;
    err_d   = err_q;
    s       = 1'b0;
    v       = 1'b0;
    done    = 1'b0;

    active   = bus_io.en & (bus_io.start | (state_q == StRun));
    // A start cycle behaves as bit 0 of digit 0 regardless of current counters.
    bit_cur  = bus_io.start ? '0 : bit_q;
    dig_cur  = bus_io.start ? '0 : dig_q;
    mode_cur = bus_io.start ? bus_io.mode : mode_q;
    // Carry is forced to 0 at each digit boundary so digits never interact.
    c_cur    = (bit_cur == '0) ? 1'b0 : c_q;
    b        = BiasVec[bit_cur];
    c_nxt    = mode_cur ? ((~bus_io.x & (b | c_cur)) | (b & c_cur))
                        : ((bus_io.x & b) | (bus_io.x & c_cur) | (b & c_cur));
    last_bit = (bit_cur == LastBit);

    if (active && !rst_i) begin
      s    = bus_io.x ^ b ^ c_cur;
      v    = last_bit & c_nxt;
      // DONE follows the running frame's counters, so it survives a coincident START.
      done = (state_q == StRun) && (bit_q == LastBit) && (dig_q == LastDig);

      mode_d = mode_cur;
      c_d    = c_nxt;
      err_d  = (bus_io.start ? 1'b0 : err_q) | v;
      if (last_bit) begin
        bit_d = '0;
        if (dig_cur == LastDig) begin
          dig_d   = '0;
          state_d = StIdle;
        end else begin
          dig_d   = dig_cur + DigW'(1);
          state_d = StRun;
        end
      end else begin
        bit_d   = bit_cur + BitW'(1);
        dig_d   = dig_cur;
        state_d = StRun;
      end
    end
  end

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      bit_q   <= '0;
      dig_q   <= '0;
      c_q     <= 1'b0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      dig_q   <= dig_d;
      c_q     <= c_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  assign bus_io.s    = s;
  assign bus_io.v    = v;
  assign bus_io.done = done;
  assign bus_io.err  = err_q;

endmodule
